// File: rtl/display_streamer.sv
// Streams NUM_WORDS result-memory words to a valid/ready sink, then returns the control unit to CALC.
// Optional macro DISP_CHECKSUM_EN appends a modulo-2^DATA_W checksum word to each full sweep.
module display_streamer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_WORDS = 392,
  parameter int unsigned CNT_W     = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] RDATA,
  output logic              addr_increment,
  output logic              clc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD,
`ifdef DISP_CHECKSUM_EN
    CKSUM,
`endif
    FINISH
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              aborted;
  logic              xfer;
  logic              last;
`ifdef DISP_CHECKSUM_EN
  logic [DATA_W-1:0] cksum;
`endif

  assign xfer = out_valid & out_ready;
  assign last = (cnt == CNT_W'(NUM_WORDS - 1));
  assign busy = (state != IDLE);
  assign clc  = (state == FINISH);
  assign done = (state == FINISH) & ~aborted;

  always_comb begin
    state_nx       = state;
    addr_increment = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = SETTLE;
      SETTLE:  state_nx = abort ? FINISH : CAPTURE;
      CAPTURE: state_nx = abort ? FINISH : HOLD;
      HOLD: begin
        if (abort) begin
          state_nx = FINISH;
        end else if (xfer) begin
          if (last) begin
`ifdef DISP_CHECKSUM_EN
            state_nx = CKSUM;
`else
            state_nx = FINISH;
`endif
          end else begin
            addr_increment = 1'b1;
            state_nx       = SETTLE;
          end
        end
      end
`ifdef DISP_CHECKSUM_EN
      CKSUM:   if (abort || xfer) state_nx = FINISH;
`endif
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      aborted   <= 1'b0;
`ifdef DISP_CHECKSUM_EN
      cksum     <= '0;
`endif
    end else begin
      if (abort && state != IDLE && state != FINISH) aborted <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            aborted <= 1'b0;
`ifdef DISP_CHECKSUM_EN
            cksum   <= '0;
`endif
          end
        end
        CAPTURE: begin
          if (!abort) begin
            out_data  <= RDATA;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (xfer || abort) out_valid <= 1'b0;
          if (xfer && !abort && !last) cnt <= cnt + 1'b1;
`ifdef DISP_CHECKSUM_EN
          if (xfer) cksum <= cksum + out_data;
          // Checksum word is the running sum including the word transferring now.
          if (xfer && !abort && last) begin
            out_data  <= cksum + out_data;
            out_valid <= 1'b1;
          end
`endif
        end
`ifdef DISP_CHECKSUM_EN
        CKSUM: if (xfer || abort) out_valid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_streamer.sv
// Directed self-checking bench for display_streamer with a scoreboard of expected stream words.
module tb_display_streamer;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 392;
`ifdef DISP_CHECKSUM_EN
  localparam int unsigned NX = NW + 1;
`else
  localparam int unsigned NX = NW;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] RDATA;
  logic          addr_increment;
  logic          clc;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  display_streamer #(.DATA_W(DW), .NUM_WORDS(NW), .CNT_W(11)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .RDATA(RDATA),
    .addr_increment(addr_increment), .clc(clc), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Control-unit address counter and synchronous-read result memory.
  logic [DW-1:0] mem [0:NW-1];
  logic [10:0]   addr = '0;
  always @(posedge CLK) begin
    if (start && !busy)     addr <= '0;
    else if (addr_increment) addr <= addr + 11'd1;
    RDATA <= mem[addr];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer, n_inc, n_clc, n_done;
  logic [DW-1:0] exp_q[$];
  logic          stall = 1'b0;
  logic [DW-1:0] stall_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(stall_data));
      end
      if (addr_increment) begin
        n_inc++;
        chk("inc_in_xfer", 32'(out_valid & out_ready), 32'd1);
      end
      if (clc)  n_clc++;
      if (done) n_done++;
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) chk("unexpected_xfer", 32'(out_data), 32'hFFFF_FFFF);
        else chk("xfer_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts();
    n_xfer = 0; n_inc = 0; n_clc = 0; n_done = 0;
  endtask

  task automatic push_sweep();
    logic [DW-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + mem[i];
    end
`ifdef DISP_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    out_ready = 1'b1;
    if (!ok) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Leaves the bench just after a clock edge where word k is on the stream.
  task automatic wait_word(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (out_valid && n_xfer == k) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_word_timeout", 32'(n_xfer), 32'(k));
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_xfers"}, 32'(n_xfer), 32'(NX));
    chk({tag, "_incs"}, 32'(n_inc), 32'(NW - 1));
    chk({tag, "_clc"}, 32'(n_clc), 32'd1);
    chk({tag, "_done"}, 32'(n_done), 32'd1);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < NW; i++) mem[i] = DW'(i + 32'h100);

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_inc", 32'(addr_increment), 32'd0);
    chk("rst_clc", 32'(clc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_clc", 32'(clc), 32'd0);

    // Full sweep, sink always ready
    clear_counts();
    push_sweep();
    pulse_start();
    tick();
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    chk("lat_first_word", 32'(out_data), 32'h100);
    wait_idle(1'b0);
    check_full("full");

    // Backpressure with pseudo-random ready
    for (int unsigned i = 0; i < NW; i++) mem[i] = DW'((i * 7) ^ 32'h5A5A);
    clear_counts();
    push_sweep();
    pulse_start();
    wait_idle(1'b1);
    check_full("bp");

    // Abort in HOLD on word 10 with a same-cycle transfer
    for (int unsigned i = 0; i < NW; i++) mem[i] = DW'(i + 32'h100);
    clear_counts();
    for (int unsigned i = 0; i <= 10; i++) exp_q.push_back(mem[i]);
    pulse_start();
    wait_word(10);
    abort = 1'b1;
    @(negedge CLK);
    chk("abort_no_inc", 32'(addr_increment), 32'd0);
    tick();
    abort = 1'b0;
    chk("abort_clc", 32'(clc), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid_drop", 32'(out_valid), 32'd0);
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_xfers", 32'(n_xfer), 32'd11);
    chk("abort_incs", 32'(n_inc), 32'd10);
    chk("abort_ndone", 32'(n_done), 32'd0);
    chk("abort_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-sweep, then restart from word 0
    clear_counts();
    push_sweep();
    pulse_start();
    wait_word(200);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_clc", 32'(clc), 32'd0);
    chk("mid_rst_inc", 32'(addr_increment), 32'd0);
    exp_q.delete();
    tick(); tick();
    RESET = 1'b0;
    chk("mid_rst_no_clc", 32'(n_clc), 32'd0);
    clear_counts();
    push_sweep();
    pulse_start();
    wait_idle(1'b0);
    check_full("restart");

    // start while busy is ignored
    clear_counts();
    push_sweep();
    pulse_start();
    wait_word(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1'b0);
    check_full("busy_start");

`ifdef DISP_CHECKSUM_EN
    // All-ones words: checksum wraps to 0xFE78
    for (int unsigned i = 0; i < NW; i++) mem[i] = 16'hFFFF;
    clear_counts();
    for (int unsigned i = 0; i < NW; i++) exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFE78);
    pulse_start();
    wait_idle(1'b0);
    check_full("cksum");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
